// File: rtl/circle_octant_draw.sv
// circle_octant_draw: midpoint circle rasteriser that emits one pixel per cycle, eight symmetric slots per step.
// Optional clipping to the visible screen is enabled by the CIRCLE_CLIP_EN macro.
//------------------------------------------------------------------------------
// Module   : circle_octant_draw
// Purpose  : IDLE -> PLOT(slots 0..7) -> UPDATE loop, DONE holds until start drops
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module circle_octant_draw #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [X_W-1:0] centre_x,
  input  logic [Y_W-1:0] centre_y,
  input  logic [X_W-1:0] radius,
  input  logic [2:0]     colour,
  input  logic [7:0]     octant_mask,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [2:0]     vga_colour,
  output logic           vga_plot,
  output logic           busy,
  output logic           done
);

  localparam int C_CW = X_W + 4;
  localparam logic signed [C_CW-1:0] C_ONE = C_CW'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PLOT   = 2'd1,
    S_UPDATE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [2:0]               slot_q, slot_d;
  logic [X_W-1:0]           cx_q, cx_d;
  logic [Y_W-1:0]           cy_q, cy_d;
  logic [2:0]               col_q, col_d;
  logic [7:0]               mask_q, mask_d;
  logic signed [C_CW-1:0]   ox_q, ox_d, oy_q, oy_d, crit_q, crit_d;

  logic signed [C_CW-1:0]   w_dx, w_dy, w_px, w_py, w_rad;
  logic signed [C_CW-1:0]   w_oy_inc, w_ox_dec, w_ox_new;
  logic                     w_crit_pos, w_clip, w_in_plot;
  logic                     w_unused;

  always_comb begin
    w_dx = ox_q;
    w_dy = oy_q;
    case (slot_q)
      3'd0: begin w_dx =  ox_q; w_dy =  oy_q; end
      3'd1: begin w_dx =  oy_q; w_dy =  ox_q; end
      3'd2: begin w_dx = -ox_q; w_dy =  oy_q; end
      3'd3: begin w_dx = -oy_q; w_dy =  ox_q; end
      3'd4: begin w_dx = -ox_q; w_dy = -oy_q; end
      3'd5: begin w_dx = -oy_q; w_dy = -ox_q; end
      3'd6: begin w_dx =  ox_q; w_dy = -oy_q; end
      default: begin w_dx = oy_q; w_dy = -ox_q; end
    endcase
  end

  // Low X_W+1 / Y_W+1 bits of the wide sums are the signed point coordinates.
  assign w_px = $signed({{(C_CW-X_W){1'b0}}, cx_q}) + w_dx;
  assign w_py = $signed({{(C_CW-Y_W){1'b0}}, cy_q}) + w_dy;

`ifdef CIRCLE_CLIP_EN
  localparam logic [X_W:0] C_XLIM = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] C_YLIM = (Y_W+1)'(SCREEN_H);
  assign w_clip = w_px[X_W] | (w_px[X_W:0] >= C_XLIM) |
                  w_py[Y_W] | (w_py[Y_W:0] >= C_YLIM);
`else
  assign w_clip = 1'b0;
`endif

  assign w_unused   = ^{w_px[C_CW-1:X_W], w_py[C_CW-1:Y_W]};
  assign w_rad      = $signed({{(C_CW-X_W){1'b0}}, radius});
  assign w_oy_inc   = oy_q + C_ONE;
  assign w_ox_dec   = ox_q - C_ONE;
  assign w_crit_pos = !crit_q[C_CW-1] && (crit_q != '0);
  assign w_ox_new   = w_crit_pos ? w_ox_dec : ox_q;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    col_d   = col_q;
    mask_d  = mask_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    crit_d  = crit_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cx_d    = centre_x;
          cy_d    = centre_y;
          col_d   = colour;
          mask_d  = octant_mask;
          ox_d    = w_rad;
          oy_d    = '0;
          crit_d  = C_ONE - w_rad;
          slot_d  = 3'd0;
          state_d = S_PLOT;
        end
      end
      S_PLOT: begin
        slot_d = slot_q + 3'd1;
        if (slot_q == 3'd7) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        oy_d   = w_oy_inc;
        ox_d   = w_ox_new;
        crit_d = w_crit_pos ? crit_q + ((w_oy_inc - w_ox_dec) <<< 1) + C_ONE
                            : crit_q + (w_oy_inc <<< 1) + C_ONE;
        slot_d  = 3'd0;
        state_d = (w_oy_inc <= w_ox_new) ? S_PLOT : S_DONE;
      end
      default: begin
        if (!start) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      slot_q  <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      col_q   <= '0;
      mask_q  <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      crit_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      col_q   <= col_d;
      mask_q  <= mask_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      crit_q  <= crit_d;
    end
  end

  assign w_in_plot  = (state_q == S_PLOT);
  assign busy       = w_in_plot || (state_q == S_UPDATE);
  assign done       = (state_q == S_DONE);
  assign vga_plot   = w_in_plot && mask_q[slot_q] && !w_clip;
  assign vga_x      = w_in_plot ? w_px[X_W-1:0] : '0;
  assign vga_y      = w_in_plot ? w_py[Y_W-1:0] : '0;
  assign vga_colour = w_in_plot ? col_q : 3'd0;

endmodule

`default_nettype wire

// File: tb/tb_circle_octant_draw.sv
// tb_circle_octant_draw: randomized and directed draws checked cycle by cycle against a midpoint-circle model.
//------------------------------------------------------------------------------
// Module   : tb_circle_octant_draw
// Purpose  : self-checking bench for circle_octant_draw (honours CIRCLE_CLIP_EN)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_circle_octant_draw;

  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int SW  = 160;
  localparam int SH  = 120;

  logic           clk = 1'b0;
  logic           rst, start;
  logic [X_W-1:0] centre_x, radius;
  logic [Y_W-1:0] centre_y;
  logic [2:0]     colour;
  logic [7:0]     octant_mask;
  logic [X_W-1:0] vga_x;
  logic [Y_W-1:0] vga_y;
  logic [2:0]     vga_colour;
  logic           vga_plot, busy, done;

  circle_octant_draw #(.X_W(X_W), .Y_W(Y_W), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
    .clk(clk), .rst(rst), .start(start),
    .centre_x(centre_x), .centre_y(centre_y), .radius(radius),
    .colour(colour), .octant_mask(octant_mask),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit plot;
    int x;
    int y;
    int col;
    bit busy;
    bit done;
  } exp_t;

  exp_t exp_q[$];
  exp_t ce;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   r40_chk  = 0;

  function automatic void chk(string nm, int act, int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, expv);
    end
  endfunction

  function automatic int wrap_s(int v, int n);
    int m = 1 << n;
    int u = ((v % m) + m) % m;
    if (u >= m / 2) u -= m;
    return u;
  endfunction

  // Expected per-cycle outputs of a full draw, from the midpoint rules in plain integers.
  function automatic void build(int cx, int cy, int r, int col, logic [7:0] mask, int ndone);
    int ox = r, oy = 0, crit = 1 - r, dx, dy, x, y;
    bit clip;
    exp_t e;
    do begin
      for (int k = 0; k < 8; k++) begin
        case (k)
          0: begin dx =  ox; dy =  oy; end
          1: begin dx =  oy; dy =  ox; end
          2: begin dx = -ox; dy =  oy; end
          3: begin dx = -oy; dy =  ox; end
          4: begin dx = -ox; dy = -oy; end
          5: begin dx = -oy; dy = -ox; end
          6: begin dx =  ox; dy = -oy; end
          default: begin dx = oy; dy = -ox; end
        endcase
        x = cx + dx;
        y = cy + dy;
        clip = 0;
`ifdef CIRCLE_CLIP_EN
        clip = (wrap_s(x, X_W+1) < 0) || (wrap_s(x, X_W+1) >= SW) ||
               (wrap_s(y, Y_W+1) < 0) || (wrap_s(y, Y_W+1) >= SH);
`endif
        e.plot = mask[k] && !clip;
        e.x    = x & ((1 << X_W) - 1);
        e.y    = y & ((1 << Y_W) - 1);
        e.col  = col;
        e.busy = 1;
        e.done = 0;
        exp_q.push_back(e);
      end
      e.plot = 0; e.busy = 1; e.done = 0;
      exp_q.push_back(e);
      oy++;
      if (crit <= 0) crit += 2*oy + 1;
      else begin
        ox--;
        crit += 2*(oy - ox) + 1;
      end
    end while (oy <= ox);
    for (int i = 0; i < ndone; i++) begin
      e.plot = 0; e.busy = 0; e.done = 1;
      exp_q.push_back(e);
    end
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ce = exp_q.pop_front();
      chk("busy", int'(busy), int'(ce.busy));
      chk("done", int'(done), int'(ce.done));
      chk("vga_plot", int'(vga_plot), int'(ce.plot));
      if (ce.plot && vga_plot) begin
        chk("vga_x", int'(vga_x), ce.x);
        chk("vga_y", int'(vga_y), ce.y);
        chk("vga_colour", int'(vga_colour), ce.col);
      end
      if (r40_chk && vga_plot) begin
        int d;
        d = (int'(vga_x) - 80) * (int'(vga_x) - 80) + (int'(vga_y) - 60) * (int'(vga_y) - 60) - 1600;
        chk("circle_err_ok", int'(d <= 40 && d >= -40), 1);
      end
    end
  end

  task automatic wait_drain();
    for (int i = 0; i < 5000; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk); #1;
    end
    chk("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Called at negedge+1; start is sampled on the following posedge.
  task automatic do_draw(int cx, int cy, int r, int col, logic [7:0] mask);
    exp_t e;
    centre_x = X_W'(cx); centre_y = Y_W'(cy); radius = X_W'(r);
    colour = 3'(col); octant_mask = mask;
    build(cx, cy, r, col, mask, 3);
    start = 1;
    @(negedge clk); #1;
    centre_x = X_W'($urandom); centre_y = Y_W'($urandom); radius = X_W'($urandom);
    colour = 3'($urandom); octant_mask = 8'($urandom);
    wait_drain();
    start = 0;
    e.plot = 0; e.busy = 0; e.done = 0; e.x = 0; e.y = 0; e.col = 0;
    exp_q.push_back(e);
    wait_drain();
  endtask

  initial begin
    int bad;
    rst = 1; start = 0; centre_x = '0; centre_y = '0; radius = '0;
    colour = '0; octant_mask = '0;

    build(80, 60, 0, 7, 8'hFF, 1);
    chk("pin_r0_len", exp_q.size(), 10);
    chk("pin_r0_x0", exp_q[0].x, 80);
    chk("pin_r0_y0", exp_q[0].y, 60);
    chk("pin_r0_upd", int'(exp_q[8].plot), 0);
    chk("pin_r0_done", int'(exp_q[9].done), 1);
    exp_q.delete();
    build(80, 60, 1, 7, 8'hFF, 1);
    chk("pin_r1_len", exp_q.size(), 19);
    chk("pin_r1_s1y", exp_q[1].y, 61);
    chk("pin_r1_i2x", exp_q[9].x, 81);
    chk("pin_r1_i2y", exp_q[9].y, 61);
    chk("pin_r1_done", int'(exp_q[18].done), 1);
    exp_q.delete();
    build(2, 2, 10, 3, 8'hFF, 0);
    chk("pin_wrap_x", exp_q[2].x, 248);
`ifdef CIRCLE_CLIP_EN
    chk("pin_wrap_plot", int'(exp_q[2].plot), 0);
`else
    chk("pin_wrap_plot", int'(exp_q[2].plot), 1);
`endif
    exp_q.delete();
    build(80, 60, 40, 1, 8'h01, 0);
    bad = 0;
    foreach (exp_q[i])
      if (exp_q[i].plot) begin
        int d;
        d = (exp_q[i].x - 80) * (exp_q[i].x - 80) + (exp_q[i].y - 60) * (exp_q[i].y - 60) - 1600;
        if (d > 40 || d < -40) bad++;
      end
    chk("pin_r40_err", bad, 0);
    chk("pin_r40_len9", exp_q.size() % 9, 0);
    exp_q.delete();

    repeat (2) @(negedge clk);
    chk("rst_x", int'(vga_x), 0);
    chk("rst_y", int'(vga_y), 0);
    chk("rst_col", int'(vga_colour), 0);
    chk("rst_plot", int'(vga_plot), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    #1 rst = 0;

    do_draw(80, 60, 0, 5, 8'hFF);
    do_draw(80, 60, 1, 2, 8'hFF);
    r40_chk = 1;
    do_draw(80, 60, 40, 6, 8'h01);
    r40_chk = 0;
    do_draw(2, 2, 10, 4, 8'hFF);

    centre_x = 8'd80; centre_y = 7'd60; radius = 8'd30; colour = 3'd1; octant_mask = 8'hA5;
    build(80, 60, 30, 1, 8'hA5, 0);
    start = 1;
    repeat (22) begin @(negedge clk); #1; end
    exp_q.delete();
    rst = 1; start = 0;
    @(negedge clk);
    chk("mid_rst_x", int'(vga_x), 0);
    chk("mid_rst_y", int'(vga_y), 0);
    chk("mid_rst_col", int'(vga_colour), 0);
    chk("mid_rst_plot", int'(vga_plot), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    #1 rst = 0;
    do_draw(80, 60, 0, 3, 8'hFF);

    for (int n = 0; n < 15; n++)
      do_draw($urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 50),
              $urandom_range(0, 7), 8'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
